// File: rtl/rvv_retire_perf_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rvv_retire_perf_monitor                                  |
// | Description : RVV retire/decode performance counters, retire-width     |
// |               histogram, backpressure run tracking and retire protocol |
// |               checker. Histogram built only with RVV_PERF_MON_HIST_EN. |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module rvv_retire_perf_monitor #(
    parameter int NUM_RT_UOP  = 4,
    parameter int NUM_DE_INST = 2,
    parameter int NUM_DE_UOP  = 6,
    parameter int CNT_W       = 32,
    parameter int RD_AW       = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              clear,
    input  logic                              halt_on_err,
    input  logic [NUM_RT_UOP-1:0]             rob2rt_write_valid,
    input  logic [NUM_RT_UOP-1:0]             rt2rob_write_ready,
    input  logic [NUM_DE_INST*NUM_DE_UOP-1:0] uop_valid_de2uq,
    input  logic [RD_AW-1:0]                  rd_addr,
    output logic [CNT_W-1:0]                  rd_data,
    output logic                              running,
    output logic                              err,
    output logic [$clog2(NUM_RT_UOP)-1:0]     err_slot,
    output logic [1:0]                        err_code
);

    localparam int               c_SLOT_W  = $clog2(NUM_RT_UOP);
    localparam int               c_NUM_UV  = NUM_DE_INST * NUM_DE_UOP;
    localparam int               c_UV_PW   = $clog2(c_NUM_UV + 1);
    localparam int               c_RT_PW   = $clog2(NUM_RT_UOP + 1);
    localparam int               c_SUM_W   = CNT_W + c_UV_PW;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_HALT = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      r_slot_cnt [NUM_RT_UOP];
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_max_run;
    logic [CNT_W-1:0]      r_run_len;
    logic [CNT_W-1:0]      r_de_uop_cnt;
    logic [CNT_W-1:0]      r_run_cycles;
    logic [CNT_W-1:0]      r_rd_data;
    logic [NUM_RT_UOP-1:0] r_prev_valid;
    logic [NUM_RT_UOP-1:0] r_prev_fire;
    logic                  r_err;
    logic [c_SLOT_W-1:0]   r_err_slot;
    logic [1:0]            r_err_code;

    logic [NUM_RT_UOP-1:0] w_fire;
    logic [NUM_RT_UOP-1:0] w_drop;
    logic [NUM_RT_UOP-1:0] w_gap;
    logic                  w_stall;
    logic                  w_in_run;
    logic                  w_err_det;
    logic [c_RT_PW-1:0]    w_fire_pop;
    logic [c_UV_PW-1:0]    w_uv_pop;
    logic [c_SUM_W-1:0]    w_de_sum;
    logic [CNT_W-1:0]      w_de_nxt;
    logic [CNT_W-1:0]      w_run_len_nxt;
    logic [CNT_W-1:0]      w_rd_mux;
    logic [c_SLOT_W-1:0]   w_err_slot;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] val, input logic inc);
        if (inc && (val != c_CNT_MAX)) return val + CNT_W'(1);
        return val;
    endfunction

    assign w_in_run = (r_state == c_S_RUN);
    assign w_fire   = rob2rt_write_valid & rt2rob_write_ready;
    assign w_stall  = |(rob2rt_write_valid & ~rt2rob_write_ready);
    assign w_drop   = r_prev_valid & ~r_prev_fire & ~rob2rt_write_valid;

    always_comb begin
        w_gap      = '0;
        w_fire_pop = '0;
        w_uv_pop   = '0;
        w_err_slot = '0;
        for (int i = 1; i < NUM_RT_UOP; i++)
            w_gap[i] = rob2rt_write_valid[i] & ~rob2rt_write_valid[i-1];
        for (int i = 0; i < NUM_RT_UOP; i++)
            w_fire_pop = w_fire_pop + c_RT_PW'(w_fire[i]);
        for (int i = 0; i < c_NUM_UV; i++)
            w_uv_pop = w_uv_pop + c_UV_PW'(uop_valid_de2uq[i]);
        // Scan downward so the lowest offending slot wins.
        for (int i = NUM_RT_UOP - 1; i >= 0; i--)
            if (w_drop[i] | w_gap[i]) w_err_slot = c_SLOT_W'(i);
    end

    assign w_err_det     = w_in_run & (|(w_drop | w_gap));
    assign w_run_len_nxt = w_stall ? f_sat_inc(r_run_len, 1'b1) : '0;
    assign w_de_sum      = {{c_UV_PW{1'b0}}, r_de_uop_cnt} + {{CNT_W{1'b0}}, w_uv_pop};
    assign w_de_nxt      = (w_de_sum > {{c_UV_PW{1'b0}}, c_CNT_MAX}) ? c_CNT_MAX : w_de_sum[CNT_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: if (start) w_state_nxt = c_S_RUN;
                c_S_RUN: begin
                    if (w_err_det && halt_on_err) w_state_nxt = c_S_HALT;
                    else if (stop)                w_state_nxt = c_S_IDLE;
                end
                c_S_HALT: w_state_nxt = c_S_HALT;
                default:  w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < NUM_RT_UOP; i++) r_slot_cnt[i] <= '0;
            r_stall_cnt  <= '0;
            r_max_run    <= '0;
            r_run_len    <= '0;
            r_de_uop_cnt <= '0;
            r_run_cycles <= '0;
            r_prev_valid <= '0;
            r_prev_fire  <= '0;
            r_err        <= 1'b0;
            r_err_slot   <= '0;
            r_err_code   <= 2'b00;
        end else begin
            if (w_in_run) begin
                for (int i = 0; i < NUM_RT_UOP; i++)
                    r_slot_cnt[i] <= f_sat_inc(r_slot_cnt[i], w_fire[i]);
                r_stall_cnt  <= f_sat_inc(r_stall_cnt, w_stall);
                r_run_len    <= w_run_len_nxt;
                if (w_run_len_nxt > r_max_run) r_max_run <= w_run_len_nxt;
                r_de_uop_cnt <= w_de_nxt;
                r_run_cycles <= f_sat_inc(r_run_cycles, 1'b1);
                r_prev_valid <= rob2rt_write_valid;
                r_prev_fire  <= w_fire;
            end else begin
                // Outside RUN the history is blanked so re-entry never flags a stale drop.
                r_prev_valid <= '0;
                r_prev_fire  <= '0;
            end
            if (w_err_det && !r_err) begin
                r_err      <= 1'b1;
                r_err_slot <= w_err_slot;
                r_err_code <= {|w_gap, |w_drop};
            end
        end
    end

`ifdef RVV_PERF_MON_HIST_EN
    logic [CNT_W-1:0] r_hist [NUM_RT_UOP+1];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int k = 0; k <= NUM_RT_UOP; k++) r_hist[k] <= '0;
        end else if (w_in_run) begin
            for (int k = 0; k <= NUM_RT_UOP; k++)
                r_hist[k] <= f_sat_inc(r_hist[k], w_fire_pop == c_RT_PW'(k));
        end
    end
`endif

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_RT_UOP; i++)
            if (rd_addr == RD_AW'(i)) w_rd_mux = r_slot_cnt[i];
        if (rd_addr == RD_AW'(NUM_RT_UOP))     w_rd_mux = r_stall_cnt;
        if (rd_addr == RD_AW'(NUM_RT_UOP + 1)) w_rd_mux = r_max_run;
        if (rd_addr == RD_AW'(NUM_RT_UOP + 2)) w_rd_mux = r_de_uop_cnt;
        if (rd_addr == RD_AW'(NUM_RT_UOP + 3)) w_rd_mux = r_run_cycles;
`ifdef RVV_PERF_MON_HIST_EN
        for (int k = 0; k <= NUM_RT_UOP; k++)
            if (rd_addr == RD_AW'(NUM_RT_UOP + 4 + k)) w_rd_mux = r_hist[k];
`endif
    end

    // Read register ignores clear so a same-cycle read returns the pre-clear value.
    always_ff @(posedge clk) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= w_rd_mux;
    end

    assign rd_data  = r_rd_data;
    assign running  = w_in_run;
    assign err      = r_err;
    assign err_slot = r_err_slot;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_rvv_retire_perf_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_rvv_retire_perf_monitor                               |
// | Description : Scoreboard bench for rvv_retire_perf_monitor; honours    |
// |               RVV_PERF_MON_HIST_EN for the expected histogram reads.   |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module tb_rvv_retire_perf_monitor;

    localparam int     N    = 4;
    localparam int     NI   = 2;
    localparam int     NU   = 6;
    localparam int     NUV  = NI * NU;
    localparam int     CW   = 8;
    localparam int     AW   = 5;
    localparam longint MAXV = (64'd1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, start, stop, clear, halt_on_err;
    logic [N-1:0]   valid, ready;
    logic [NUV-1:0] uv;
    logic [AW-1:0]  rd_addr;
    logic [CW-1:0]  rd_data;
    logic           running, err;
    logic [1:0]     err_slot, err_code;

    rvv_retire_perf_monitor #(
        .NUM_RT_UOP(N), .NUM_DE_INST(NI), .NUM_DE_UOP(NU), .CNT_W(CW), .RD_AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .halt_on_err(halt_on_err), .rob2rt_write_valid(valid), .rt2rob_write_ready(ready),
        .uop_valid_de2uq(uv), .rd_addr(rd_addr), .rd_data(rd_data), .running(running),
        .err(err), .err_slot(err_slot), .err_code(err_code)
    );

    typedef struct {
        int     addr;
        longint rd;
        bit     running;
        bit     err;
        int     slot;
        int     code;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: counters as plain integers, clipped to the counter range.
    typedef enum {M_IDLE, M_RUN, M_HALT} mst_t;
    mst_t         m_st;
    longint       m_slot[N];
    longint       m_hist[N+1];
    longint       m_stall, m_maxrun, m_runlen, m_de, m_rc;
    logic [N-1:0] m_pv, m_pf;
    bit           m_err;
    int           m_eslot, m_ecode;

    function automatic longint sat(input longint x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    function automatic longint m_read(input int a);
        if (a < N)      return m_slot[a];
        if (a == N)     return m_stall;
        if (a == N + 1) return m_maxrun;
        if (a == N + 2) return m_de;
        if (a == N + 3) return m_rc;
`ifdef RVV_PERF_MON_HIST_EN
        if (a >= N + 4 && a <= 2 * N + 4) return m_hist[a - N - 4];
`endif
        return 0;
    endfunction

    task automatic m_zero();
        for (int i = 0; i < N; i++)  m_slot[i] = 0;
        for (int k = 0; k <= N; k++) m_hist[k] = 0;
        m_stall = 0; m_maxrun = 0; m_runlen = 0; m_de = 0; m_rc = 0;
        m_pv = '0; m_pf = '0; m_err = 0; m_eslot = 0; m_ecode = 0;
        m_st = M_IDLE;
    endtask

    task automatic m_step();
        logic [N-1:0] f;
        bit any, d, g;
        int lo, code;
        if (!rst_n || clear) begin
            m_zero();
        end else if (m_st == M_RUN) begin
            f = valid & ready;
            any = 0; lo = 0; code = 0;
            for (int i = N - 1; i >= 0; i--) begin
                d = m_pv[i] && !m_pf[i] && !valid[i];
                g = 0;
                if (i > 0) g = valid[i] && !valid[i-1];
                if (d || g) begin any = 1; lo = i; end
                if (d) code = code | 1;
                if (g) code = code | 2;
            end
            for (int i = 0; i < N; i++) if (f[i]) m_slot[i] = sat(m_slot[i] + 1);
            m_hist[$countones(f)] = sat(m_hist[$countones(f)] + 1);
            if ((valid & ~ready) != '0) begin
                m_stall  = sat(m_stall + 1);
                m_runlen = sat(m_runlen + 1);
            end else begin
                m_runlen = 0;
            end
            if (m_runlen > m_maxrun) m_maxrun = m_runlen;
            m_de = sat(m_de + $countones(uv));
            m_rc = sat(m_rc + 1);
            if (any && !m_err) begin m_err = 1; m_eslot = lo; m_ecode = code; end
            if (any && halt_on_err) m_st = M_HALT;
            else if (stop)          m_st = M_IDLE;
            m_pv = valid; m_pf = f;
        end else begin
            if (m_st == M_IDLE && start) m_st = M_RUN;
            m_pv = '0; m_pf = '0;
        end
    endtask

    // Push the response expected after the coming rising edge, then advance.
    task automatic step();
        exp_t e;
        e.addr = int'(rd_addr);
        e.rd   = rst_n ? m_read(int'(rd_addr)) : 0;
        m_step();
        e.running = (m_st == M_RUN);
        e.err     = m_err;
        e.slot    = m_eslot;
        e.code    = m_ecode;
        q.push_back(e);
        @(negedge clk);
        start = 0; stop = 0; clear = 0;
        rd_addr = AW'($urandom_range(0, 2 * N + 6));
    endtask

    task automatic read_all();
        for (int a = 0; a <= 2 * N + 6; a++) begin
            rd_addr = AW'(a);
            step();
        end
        rd_addr = AW'(31);
        step();
    endtask

    task automatic check(input string nm, input int a, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s (rd_addr=%0d): got %0d, expected %0d", nm, a, got, want);
        end
    endtask

    exp_t me;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            me = q.pop_front();
            check("rd_data",  me.addr, longint'(rd_data),  me.rd);
            check("running",  me.addr, longint'(running),  longint'(me.running));
            check("err",      me.addr, longint'(err),      longint'(me.err));
            check("err_slot", me.addr, longint'(err_slot), longint'(me.slot));
            check("err_code", me.addr, longint'(err_code), longint'(me.code));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        m_zero();
        rst_n = 0; start = 0; stop = 0; clear = 0; halt_on_err = 0;
        valid = '0; ready = '0; uv = '0; rd_addr = '0;
        repeat (3) step();
        rst_n = 1;
        read_all();

        // Full-width retire for ten counted cycles.
        start = 1; step();
        for (int i = 0; i < 10; i++) begin
            valid = 4'b1111; ready = 4'b1111;
            if (i == 9) stop = 1;
            step();
        end
        valid = '0; ready = '0;
        read_all();

        // Slot 1 backpressured for five cycles, then released.
        clear = 1; step();
        start = 1; step();
        for (int i = 0; i < 6; i++) begin
            valid = 4'b0011; ready = (i == 5) ? 4'b0011 : 4'b0001;
            if (i == 5) stop = 1;
            step();
        end
        valid = '0; ready = '0;
        read_all();

        // Non-contiguous valid with halt enabled, then recovery via clear.
        clear = 1; step();
        start = 1; step();
        halt_on_err = 1; valid = 4'b0101; ready = 4'b0000; step();
        valid = 4'b1111; ready = 4'b1111;
        read_all();
        start = 1; step();
        clear = 1; rd_addr = AW'(N); step();
        halt_on_err = 0; valid = '0; ready = '0;
        read_all();

        // Valid dropped without firing.
        start = 1; step();
        valid = 4'b0001; ready = 4'b0000; step();
        valid = 4'b0000; step();
        stop = 1; step();
        read_all();

        // Decode uop counter saturation.
        clear = 1; step();
        start = 1; step();
        uv = '1;
        for (int i = 0; i < 25; i++) begin rd_addr = AW'(N + 2); step(); end
        uv = '0; stop = 1; step();
        read_all();

        // Randomised traffic with occasional control pulses.
        clear = 1; step();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) != 0) valid = N'((1 << $urandom_range(0, N)) - 1);
            else                           valid = N'($urandom());
            ready       = N'($urandom());
            uv          = NUV'($urandom());
            start       = ($urandom_range(0, 7) == 0);
            stop        = ($urandom_range(0, 11) == 0);
            clear       = ($urandom_range(0, 59) == 0);
            halt_on_err = ($urandom_range(0, 3) == 0);
            if (c % 300 == 150) rst_n = 0;
            else                rst_n = 1;
            step();
        end
        rst_n = 1;
        read_all();

        repeat (2) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
